imem_program_loader: RTL and testbench

- Writer-side counterpart of the control decoder: accepts instruction requests (opcode + operand) over a valid/ready stream and checks them against decoder legality.
- Packs each request into the 16-bit instruction word that the decoder consumes and writes it sequentially into instruction memory from a base address.
- Sits between the testbench/boot source and instruction memory. A load runs until the halt word is written, or until an error occurs.

---
 rtl/isa_pkg.sv | 53 +++++
 rtl/sync_fifo.sv | 43 ++++
 rtl/imem_program_loader.sv | 110 +++++++++++
 tb/tb_imem_program_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: instruction-set constants shared by the program loader and the control decoder
package isa_pkg;
   // Field layout of the 16-bit instruction word: opcode [15:12], operand [11:0]
   localparam int OPC_W   = 4;
   localparam int OPR_W   = 12;
   localparam int OPC_LSB = 12;
   localparam int OPR_LSB = 0;

   localparam logic [OPC_W-1:0] OP_RESULT = 4'd0;
   localparam logic [OPC_W-1:0] OP_MOVE   = 4'd1;
   localparam logic [OPC_W-1:0] OP_ADD    = 4'd2;
   localparam logic [OPC_W-1:0] OP_SUB    = 4'd3;
   localparam logic [OPC_W-1:0] OP_JBI    = 4'd4;
   localparam logic [OPC_W-1:0] OP_AND    = 4'd5;
   localparam logic [OPC_W-1:0] OP_OR     = 4'd6;
   localparam logic [OPC_W-1:0] OP_XOR    = 4'd7;
   localparam logic [OPC_W-1:0] OP_SHIFT  = 4'd8;
   localparam logic [OPC_W-1:0] OP_CMP    = 4'd9;
   localparam logic [OPC_W-1:0] OP_BRANCH = 4'd10;
   localparam logic [OPC_W-1:0] OP_LOAD   = 4'd11;
   localparam logic [OPC_W-1:0] OP_STORE  = 4'd12;
   localparam logic [OPC_W-1:0] OP_CALL   = 4'd13;
   localparam logic [OPC_W-1:0] OP_RETURN = 4'd14;
   localparam logic [OPC_W-1:0] OP_BAD    = 4'd15;

   localparam logic [OPR_W-1:0] RES_HALT   = 12'd0;
   localparam logic [OPR_W-1:0] RES_OUT    = 12'd1;
   localparam logic [OPR_W-1:0] RES_ZERO   = 12'd2;
   localparam logic [OPR_W-1:0] RES_CARRY  = 12'd3;
   localparam logic [OPR_W-1:0] RES_BRANCH = 12'd4;

   localparam logic [OPR_W-1:0] JB_INIT = 12'd0;
   localparam logic [OPR_W-1:0] JB_FWD  = 12'd1;
   localparam logic [OPR_W-1:0] JB_BACK = 12'd2;

   localparam logic [OPC_W+OPR_W-1:0] HALT_WORD = {OP_RESULT, RES_HALT};

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_ILLEGAL  = 2'd1,
      ERR_OVERFLOW = 2'd2
   } err_e;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      logic [OPR_W-1:0] operand;
   } instr_t;

   // A request the decoder would reject: reserved opcode or out-of-range sub-select
   function automatic logic is_illegal(input logic [OPC_W-1:0] opc, input logic [OPR_W-1:0] opr);
      return opc == OP_BAD || (opc == OP_RESULT && opr > RES_BRANCH) || (opc == OP_JBI && opr > JB_BACK);
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small synchronous FIFO with flush; push and pop may coincide even when full
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wp, rp;

   assign empty = wp == rp;
   assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
   assign rdata = mem[rp[AW-1:0]];

   // Pointers carry an extra wrap bit so full and empty are distinguishable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
      end
   end

   // Storage needs no reset; a slot is only read after it has been written
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wp[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader: checks, packs and streams instruction requests into instruction memory
module imem_program_loader
   import isa_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int INSTR_W    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [ADDR_W-1:0]  base_addr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_opcode,
   input  logic [11:0]        in_operand,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code,
   output logic [ADDR_W:0]    count
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]         state;
   logic [ADDR_W-1:0]  wr_addr;
   logic               top_written;
   logic               fifo_full, fifo_empty;
   logic               accept, illegal, is_halt, pending, ovf, push, flush;
   logic [INSTR_W-1:0] head;
   instr_t             req;

   assign req        = '{opcode: in_opcode, operand: in_operand};
   assign busy       = state != S_IDLE;
   assign in_ready   = state == S_LOAD && !fifo_full;
   assign accept     = in_valid && in_ready;
   assign illegal    = is_illegal(in_opcode, in_operand);
   assign is_halt    = req == HALT_WORD;
   // Once the last address has been written, any further pending word is an overflow, never a wrap
   assign pending    = busy && !fifo_empty;
   assign ovf        = pending && top_written;
   assign imem_we    = pending && !top_written;
   assign imem_addr  = wr_addr;
   assign imem_wdata = head;
   assign push       = accept && !illegal && !ovf;
   assign flush      = ovf || (accept && illegal);

   sync_fifo #(.WIDTH(INSTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (imem_we),
      .flush (flush),
      .wdata (req),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Load sequencing: overflow beats everything, an illegal request aborts, the halt word ends the load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         wr_addr     <= '0;
         top_written <= 1'b0;
         count       <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_code    <= ERR_NONE;
      end else begin
         done <= 1'b0;
         if (state == S_IDLE) begin
            if (start) begin
               state       <= S_LOAD;
               wr_addr     <= base_addr;
               top_written <= 1'b0;
               count       <= '0;
               err         <= 1'b0;
               err_code    <= ERR_NONE;
            end
         end else if (ovf) begin
            state    <= S_IDLE;
            err      <= 1'b1;
            err_code <= ERR_OVERFLOW;
         end else begin
            if (imem_we) begin
               wr_addr     <= wr_addr + 1'b1;
               count       <= count + 1'b1;
               top_written <= &wr_addr;
               if (head == HALT_WORD) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
            end
            if (accept && illegal) begin
               state    <= S_IDLE;
               err      <= 1'b1;
               err_code <= ERR_ILLEGAL;
            end else if (accept && is_halt) begin
               state <= S_DRAIN;
            end
         end
      end
   end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: randomized loads checked by a request-level reference model and scoreboard
module tb_imem_program_loader;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
   logic [7:0]  base_addr = '0;
   logic [3:0]  in_opcode = '0;
   logic [11:0] in_operand = '0;
   logic        in_ready, imem_we, busy, done, err;
   logic [7:0]  imem_addr;
   logic [15:0] imem_wdata;
   logic [1:0]  err_code;
   logic [8:0]  count;

   typedef struct {int addr; int data;} wr_t;
   typedef struct {int code; int cnt;} end_t;

   wr_t         exp_q[$];
   end_t        end_q[$];
   logic [15:0] req_q[$];
   wr_t         mon_w;
   end_t        mon_e;
   int          n_chk = 0, n_fail = 0;
   bit          mon_en = 1'b0;
   logic        err_q = 1'b0, we_q = 1'b0;
   int          len;
   logic [7:0]  rb;

   imem_program_loader #(.ADDR_W(8), .FIFO_DEPTH(4), .INSTR_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_operand (in_operand),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .err_code   (err_code),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name, input logic [31:0] act);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got 0x%0h expected nothing at %0t", name, act, $time);
   endtask

   // Decoder legality rules stated directly on the request fields
   function automatic bit ref_illegal(input logic [15:0] w);
      int opc = int'(w[15:12]);
      int opr = int'(w[11:0]);
      return opc == 15 || (opc == 0 && opr > 4) || (opc == 4 && opr > 2);
   endfunction

   // Walk the request list: each legal word lands at the next address until halt, an illegal request or the end of memory
   task automatic plan(input int base, output int nsend);
      int a = base;
      int nwr = 0;
      nsend = req_q.size();
      foreach (req_q[i]) begin
         if (ref_illegal(req_q[i])) begin
            end_q.push_back(end_t'{1, nwr});
            nsend = i + 1;
            return;
         end
         if (a >= 256) begin
            end_q.push_back(end_t'{2, nwr});
            return;
         end
         exp_q.push_back(wr_t'{a, int'(req_q[i])});
         a++;
         nwr++;
         if (req_q[i] == 16'h0000) begin
            end_q.push_back(end_t'{0, nwr});
            nsend = i + 1;
            return;
         end
      end
   endtask

   function automatic logic [15:0] rand_word();
      int r = $urandom_range(0, 29);
      logic [3:0] o = 4'($urandom_range(1, 14));
      if (r == 0) return {4'hF, 12'($urandom)};
      if (r == 1) return {4'h0, 12'($urandom_range(5, 4095))};
      if (r == 2) return {4'h4, 12'($urandom_range(3, 4095))};
      if (r < 6) return {4'h0, 12'($urandom_range(1, 4))};
      return {o, o == 4'd4 ? 12'($urandom_range(0, 2)) : 12'($urandom)};
   endfunction

   // Monitor: pops the scoreboard whenever the DUT writes or finishes a load
   always @(negedge clk) begin
      if (mon_en) begin
         check("done_err_excl", {31'd0, done & err}, 32'd0);
         if (imem_we) begin
            if (exp_q.size() == 0) fail("unexpected_write", {imem_addr, 8'd0, imem_wdata});
            else begin
               mon_w = exp_q.pop_front();
               check("wr_addr", {24'd0, imem_addr}, mon_w.addr);
               check("wr_data", {16'd0, imem_wdata}, mon_w.data);
            end
         end
         if (done || (err && !err_q)) begin
            if (end_q.size() == 0) fail("unexpected_end", {30'd0, err_code});
            else begin
               mon_e = end_q.pop_front();
               check("end_code", done ? 32'd0 : {30'd0, err_code}, mon_e.code);
               check("end_count", {23'd0, count}, mon_e.cnt);
               if (done) check("done_after_halt_write", {31'd0, we_q}, 32'd1);
            end
         end
         err_q = err;
         we_q  = imem_we;
      end
   end

   task automatic send(input logic [15:0] w, input int gap, input bit noise, input bit chk_ready, output bit ok);
      ok = 1'b0;
      for (int k = 0; k <= gap + 20; k++) begin
         @(negedge clk);
         if (!busy) begin
            in_valid = 1'b0;
            start    = 1'b0;
            return;
         end
         start = noise && $urandom_range(0, 3) == 0;
         in_valid = k >= gap;
         {in_opcode, in_operand} = w;
         if (in_valid) begin
            if (chk_ready) check("in_ready_held", {31'd0, in_ready}, 32'd1);
            if (in_ready) begin
               @(posedge clk);
               ok = 1'b1;
               return;
            end
         end
      end
      in_valid = 1'b0;
      start    = 1'b0;
      fail("send_timeout", {16'd0, w});
   endtask

   task automatic run_load(input logic [7:0] base, input int gap_max, input bit noise, input bit chk_ready);
      int nsend;
      bit ok;
      plan(int'(base), nsend);
      @(negedge clk);
      base_addr = base;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("err_cleared", {31'd0, err}, 32'd0);
      for (int i = 0; i < nsend; i++) begin
         send(req_q[i], $urandom_range(0, gap_max), noise, chk_ready, ok);
         if (!ok) break;
      end
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      for (int k = 0; k < 40 && busy; k++) @(negedge clk);
      check("load_ends", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("exp_writes_left", exp_q.size(), 32'd0);
      check("exp_ends_left", end_q.size(), 32'd0);
      req_q.delete();
      exp_q.delete();
      end_q.delete();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_we", {31'd0, imem_we}, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_err_code", {30'd0, err_code}, 32'd0);
      check("rst_count", {23'd0, count}, 32'd0);
      mon_en = 1'b1;

      req_q = '{16'h1005, 16'h5001, 16'h0000};
      run_load(8'h10, 0, 1'b0, 1'b0);

      req_q = '{16'h1001, 16'h2002, 16'h0005, 16'h3003, 16'h0000};
      run_load(8'h20, 0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("err_sticky", {31'd0, err}, 32'd1);
      check("err_code_illegal", {30'd0, err_code}, 32'd1);
      check("err_not_busy", {31'd0, busy}, 32'd0);

      req_q = '{16'h1001, 16'h2002, 16'h3003, 16'h0000};
      run_load(8'hFE, 0, 1'b0, 1'b0);
      check("err_code_ovf", {30'd0, err_code}, 32'd2);

      req_q = '{16'h1111, 16'h2222, 16'h3333, 16'h5555, 16'h6666, 16'h0000};
      run_load(8'h30, 0, 1'b1, 1'b1);

      mon_en = 1'b0;
      @(negedge clk);
      base_addr = 8'h40;
      start     = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      {in_opcode, in_operand} = 16'h1ABC;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      check("we_before_reset", {31'd0, imem_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("we_async_drop", {31'd0, imem_we}, 32'd0);
      check("busy_async_drop", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'd0, in_ready}, 32'd0);
      check("post_rst_count", {23'd0, count}, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      end_q.delete();
      err_q  = 1'b0;
      we_q   = 1'b0;
      mon_en = 1'b1;

      req_q = '{16'hF123, 16'h1001, 16'h0000};
      run_load(8'h50, 0, 1'b0, 1'b0);
      req_q = '{16'h4002, 16'h0000};
      run_load(8'h60, 0, 1'b0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         len = $urandom_range(1, 10);
         rb  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
         for (int i = 0; i < len; i++) req_q.push_back(rand_word());
         req_q.push_back(16'h0000);
         run_load(rb, 2, 1'b1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
